// File: rtl/instr_fetch_unit.sv
// Instruction-fetch sequencer: owns the program counter, drives the
// instruction RAM pins, waits MEM_LAT cycles per read and hands each word
// to decode over a valid/ready handshake. Supports branch redirect with
// flush, a halting end address and a saturating retired-instruction count.
module instr_fetch_unit #(
  parameter int ADDR_W     = 16,
  parameter int INSTR_W    = 32,
  parameter int MEM_LAT    = 1,
  parameter int START_ADDR = 0,
  parameter int END_ADDR   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  output logic               Enable_i,
  output logic               RW_ram_i,
  output logic [ADDR_W-1:0]  Address_in_i,
  input  logic [INSTR_W-1:0] Out_i,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  Instr_pc,
  output logic               Instr_valid,
  input  logic               Instr_ready,
  input  logic               Branch_taken,
  input  logic [ADDR_W-1:0]  Branch_target,
  output logic               Halted,
  output logic [15:0]        Retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1'b1);
  localparam logic [3:0]        LAT_C   = 4'(MEM_LAT);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    pc_inc;
  logic [3:0]           cnt_q, cnt_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    ipc_q, ipc_d;
  logic [15:0]          retired_q, retired_d;
  logic                 en_q, en_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;

  // The RAM is only ever read from.
  assign RW_ram_i     = 1'b1;
  assign Enable_i     = en_q;
  assign Address_in_i = addr_q;
  assign Instr        = instr_q;
  assign Instr_pc     = ipc_q;
  assign Instr_valid  = valid_q;
  assign Halted       = halted_q;
  assign Retired      = retired_q;

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath: branch beats accept, end check only on sequential increment.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    retired_d = retired_q;
    pc_inc    = pc_q + PC_ONE;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_d   = S_FETCH;
          pc_d      = START_A;
          cnt_d     = 4'd1;
          retired_d = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        if (Branch_taken) begin
          pc_d  = Branch_target;
          cnt_d = 4'd1;
        end else if (cnt_q == LAT_C) begin
          instr_d = Out_i;
          ipc_d   = pc_q;
          cnt_d   = 4'd0;
          state_d = S_VALID;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_VALID: begin
        if (Branch_taken) begin
          state_d = S_FETCH;
          pc_d    = Branch_target;
          cnt_d   = 4'd1;
        end else if (Instr_ready) begin
          retired_d = (retired_q == 16'hFFFF) ? retired_q : (retired_q + 16'd1);
          pc_d      = pc_inc;
          if (pc_inc == END_A) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            cnt_d   = 4'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the RAM pins and handshake are registered.
  always_comb begin
    en_d     = (state_d == S_FETCH);
    valid_d  = (state_d == S_VALID);
    halted_d = (state_d == S_HALT);
    if (state_d == S_FETCH) begin
      addr_d = pc_d;
    end else begin
      addr_d = addr_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q      <= START_A;
      cnt_q     <= 4'd0;
      instr_q   <= {INSTR_W{1'b0}};
      ipc_q     <= {ADDR_W{1'b0}};
      retired_q <= 16'd0;
      en_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      retired_q <= retired_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: three configurations share one
// stimulus stream and each is compared every cycle against a
// transaction-level model of the fetch/deliver/halt behaviour.
module tb_instr_fetch_unit;

  localparam int N = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Instr_ready;
  logic        Branch_taken;
  logic [15:0] tgt;

  // DUT 0: MEM_LAT=3, 0..16 ; DUT 1: ADDR_W=4, 14..0 wrap ; DUT 2: MEM_LAT=1, 0..16
  logic        en0, rw0, valid0, halt0;
  logic [15:0] addr0, ipc0, ret0;
  logic [31:0] out0, instr0;
  logic        en1, rw1, valid1, halt1;
  logic [3:0]  addr1, ipc1;
  logic [15:0] ret1;
  logic [31:0] out1, instr1;
  logic        en2, rw2, valid2, halt2;
  logic [15:0] addr2, ipc2, ret2;
  logic [31:0] out2, instr2;

  logic        o_en[N], o_rw[N], o_valid[N], o_halt[N];
  logic [15:0] o_addr[N], o_ipc[N], o_ret[N];
  logic [31:0] o_instr[N];

  // Reference model state
  bit          m_fetch[N], m_hold[N], m_halt[N];
  int          m_left[N];
  logic [15:0] m_pc[N], m_ret[N], m_ipc[N], m_addr[N];
  logic [31:0] m_instr[N];

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] word(input logic [15:0] a);
    return ({a, a} ^ 32'h5A3C_0F96) + {16'h0, a} * 32'd7919;
  endfunction

  function automatic int p_lat(input int k);
    case (k)
      0: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [15:0] p_start(input int k);
    return (k == 1) ? 16'd14 : 16'd0;
  endfunction

  function automatic logic [15:0] p_end(input int k);
    return (k == 1) ? 16'd0 : 16'd16;
  endfunction

  function automatic logic [15:0] p_mask(input int k);
    return (k == 1) ? 16'h000F : 16'hFFFF;
  endfunction

  assign out0 = en0 ? word(addr0) : 32'hDEAD_BEEF;
  assign out1 = en1 ? word({12'd0, addr1}) : 32'hDEAD_BEEF;
  assign out2 = en2 ? word(addr2) : 32'hDEAD_BEEF;

  assign o_en[0] = en0;  assign o_rw[0] = rw0;  assign o_valid[0] = valid0;
  assign o_halt[0] = halt0; assign o_addr[0] = addr0; assign o_ipc[0] = ipc0;
  assign o_ret[0] = ret0; assign o_instr[0] = instr0;
  assign o_en[1] = en1;  assign o_rw[1] = rw1;  assign o_valid[1] = valid1;
  assign o_halt[1] = halt1; assign o_addr[1] = {12'd0, addr1}; assign o_ipc[1] = {12'd0, ipc1};
  assign o_ret[1] = ret1; assign o_instr[1] = instr1;
  assign o_en[2] = en2;  assign o_rw[2] = rw2;  assign o_valid[2] = valid2;
  assign o_halt[2] = halt2; assign o_addr[2] = addr2; assign o_ipc[2] = ipc2;
  assign o_ret[2] = ret2; assign o_instr[2] = instr2;

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .MEM_LAT(3), .START_ADDR(0), .END_ADDR(16)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Enable_i(en0), .RW_ram_i(rw0),
    .Address_in_i(addr0), .Out_i(out0), .Instr(instr0), .Instr_pc(ipc0),
    .Instr_valid(valid0), .Instr_ready(Instr_ready), .Branch_taken(Branch_taken),
    .Branch_target(tgt), .Halted(halt0), .Retired(ret0));

  instr_fetch_unit #(.ADDR_W(4), .INSTR_W(32), .MEM_LAT(1), .START_ADDR(14), .END_ADDR(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Enable_i(en1), .RW_ram_i(rw1),
    .Address_in_i(addr1), .Out_i(out1), .Instr(instr1), .Instr_pc(ipc1),
    .Instr_valid(valid1), .Instr_ready(Instr_ready), .Branch_taken(Branch_taken),
    .Branch_target(tgt[3:0]), .Halted(halt1), .Retired(ret1));

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .MEM_LAT(1), .START_ADDR(0), .END_ADDR(16)) dut2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Enable_i(en2), .RW_ram_i(rw2),
    .Address_in_i(addr2), .Out_i(out2), .Instr(instr2), .Instr_pc(ipc2),
    .Instr_valid(valid2), .Instr_ready(Instr_ready), .Branch_taken(Branch_taken),
    .Branch_target(tgt), .Halted(halt2), .Retired(ret2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) begin
        $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_fetch[k] = 1'b0; m_hold[k] = 1'b0; m_halt[k] = 1'b0; m_left[k] = 0;
      m_pc[k] = p_start(k); m_ret[k] = 16'd0; m_ipc[k] = 16'd0;
      m_addr[k] = 16'd0; m_instr[k] = 32'd0;
    end
  endtask

  // One clock edge of behaviour: a fetch takes p_lat cycles, a held word
  // retires on ready, a branch restarts the fetch at the target.
  task automatic model_step(input int k);
    logic [15:0] t;
    t = tgt & p_mask(k);
    if (m_fetch[k]) begin
      if (Branch_taken) begin
        m_pc[k] = t; m_left[k] = p_lat(k);
      end else if (m_left[k] == 1) begin
        m_instr[k] = word(m_pc[k]); m_ipc[k] = m_pc[k];
        m_fetch[k] = 1'b0; m_hold[k] = 1'b1;
      end else begin
        m_left[k] = m_left[k] - 1;
      end
    end else if (m_hold[k]) begin
      if (Branch_taken) begin
        m_hold[k] = 1'b0; m_fetch[k] = 1'b1; m_pc[k] = t; m_left[k] = p_lat(k);
      end else if (Instr_ready) begin
        m_hold[k] = 1'b0;
        if (m_ret[k] != 16'hFFFF) m_ret[k] = m_ret[k] + 16'd1;
        m_pc[k] = (m_pc[k] + 16'd1) & p_mask(k);
        if (m_pc[k] == p_end(k)) begin
          m_halt[k] = 1'b1;
        end else begin
          m_fetch[k] = 1'b1; m_left[k] = p_lat(k);
        end
      end
    end else if (Start) begin
      m_pc[k] = p_start(k); m_fetch[k] = 1'b1; m_left[k] = p_lat(k);
      m_halt[k] = 1'b0; m_ret[k] = 16'd0;
    end
    if (m_fetch[k]) m_addr[k] = m_pc[k];
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("d%0d_enable", k), {31'd0, o_en[k]}, {31'd0, m_fetch[k]});
      chk($sformatf("d%0d_rw", k), {31'd0, o_rw[k]}, 32'd1);
      chk($sformatf("d%0d_addr", k), {16'd0, o_addr[k]}, {16'd0, m_addr[k]});
      chk($sformatf("d%0d_valid", k), {31'd0, o_valid[k]}, {31'd0, m_hold[k]});
      chk($sformatf("d%0d_halted", k), {31'd0, o_halt[k]}, {31'd0, m_halt[k]});
      chk($sformatf("d%0d_retired", k), {16'd0, o_ret[k]}, {16'd0, m_ret[k]});
      chk($sformatf("d%0d_instr", k), o_instr[k], m_instr[k]);
      chk($sformatf("d%0d_instr_pc", k), {16'd0, o_ipc[k]}, {16'd0, m_ipc[k]});
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    for (int k = 0; k < N; k++) model_step(k);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted mid-cycle, held over one edge, released mid-cycle.
  task automatic mid_reset();
    Start = 1'b0; Branch_taken = 1'b0;
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge Clk);
    #1;
    check_all();
    #2 Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Instr_ready = 1'b0; Branch_taken = 1'b0; tgt = 16'd0;
    model_reset();
    #3;
    check_all();
    #10 Reset = 1'b1;
    #4;

    // Straight-line run with ready tied high.
    Start = 1'b1; Instr_ready = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("d2_halted_after_16", {31'd0, o_halt[2]}, 32'd1);
    chk("d2_retired_16", {16'd0, o_ret[2]}, 32'd16);
    chk("d1_wrap_halted", {31'd0, o_halt[1]}, 32'd1);
    chk("d1_retired_2", {16'd0, o_ret[1]}, 32'd2);
    chk("d0_retired_10", {16'd0, o_ret[0]}, 32'd10);

    // Reset in the middle of activity, then restart.
    mid_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("idle_until_start", {31'd0, o_en[0]}, 32'd0);

    // Random stimulus with periodic mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      Start        = ($urandom_range(0, 15) == 0);
      Instr_ready  = ($urandom_range(0, 2) != 0);
      Branch_taken = ($urandom_range(0, 9) == 0);
      tgt          = 16'($urandom_range(0, 16));
      tick();
      if ((i % 700) == 699) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Parametrised instruction-fetch sequencer that replaces bench-driven stepping of the instruction RAM address.
- Owns the program counter and drives the RAM_i enable, read/write and address pins.
- Waits a configurable read latency, then presents each instruction to the decode stage over a valid/ready handshake.
- Supports branch redirect with flush, a programmable end address that halts the unit, and a retired-instruction counter.

Parameters:
ADDR_W, 16, width of PC and instruction RAM address
INSTR_W, 32, instruction width
MEM_LAT, 1, instruction RAM read latency in cycles (legal 1..8)
START_ADDR, 0, PC loaded on Start
END_ADDR, 16, PC value at which fetch halts; this address is never fetched

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  one-cycle pulse; begins fetch from START_ADDR (honoured only in IDLE or HALT)
Enable_i  output  1  instruction RAM enable
RW_ram_i  output  1  RAM read/write select; tied 1 (read), never 0
Address_in_i  output  ADDR_W  instruction RAM address
Out_i  input  INSTR_W  instruction RAM read data
Instr  output  INSTR_W  captured instruction to decode
Instr_pc  output  ADDR_W  address of Instr
Instr_valid  output  1  Instr/Instr_pc valid
Instr_ready  input  1  decode accepts this cycle
Branch_taken  input  1  redirect request, single-cycle
Branch_target  input  ADDR_W  redirect address
Halted  output  1  high in HALT state
Retired  output  16  count of accepted instructions, saturating at 16'hFFFF

Behaviour:
- Reset low (async) forces:
  - state IDLE; PC=START_ADDR; latency counter=0
  - Enable_i=0, RW_ram_i=1, Address_in_i=0
  - Instr=0, Instr_pc=0, Instr_valid=0, Halted=0, Retired=0
- Release of Reset is sampled on the next rising edge.
- IDLE:
  - Enable_i=0.
  - Start=1 → FETCH; PC=START_ADDR; Retired cleared.
- FETCH:
  - Enable_i=1 and Address_in_i=PC, held stable for the whole state.
  - Latency counter counts cycles in FETCH, starting at 1.
  - On the edge ending the MEM_LAT-th cycle: Out_i captured into Instr, PC into Instr_pc; go to VALID.
  - MEM_LAT=1 gives capture at the end of the first FETCH cycle.
- VALID:
  - Instr_valid=1; Enable_i=0; Instr and Instr_pc held stable until accepted.
  - On an edge with Instr_ready=1: Retired+=1 (saturating); next PC = PC+1 (mod 2^ADDR_W).
    - Next PC == END_ADDR → HALT.
    - Otherwise → FETCH with counter restarted.
  - Instr_ready=0: stay in VALID, no change.
- HALT:
  - Halted=1, Enable_i=0, Instr_valid=0.
  - Start → FETCH from START_ADDR, Retired cleared, Halted drops the next cycle.
- Branch (FETCH or VALID): Branch_taken=1 at an edge →
  - PC=Branch_target; the in-flight fetch or held instruction is discarded and Instr_valid=0 the next cycle.
  - Enter FETCH with counter restarted.
  - Branch has priority over a simultaneous Instr_ready; the discarded instruction does NOT increment Retired.
  - Branch_target == END_ADDR is still fetched. The end-address check applies only to sequential increment.
- Branch_taken in IDLE or HALT is ignored.
- Start while in FETCH or VALID is ignored.
- Instr_valid never asserts in the same cycle that Enable_i is high. There is one outstanding fetch at most.
- PC wrap: 2^ADDR_W-1 increments to 0 unless END_ADDR intervenes.
- Reset asserted mid-fetch or mid-handshake aborts immediately to the reset values; no partial capture.

Test Plan:
- MEM_LAT=1, instructions.txt 16 words, END_ADDR=16, Instr_ready tied 1, pulse Start → addresses 0..15 fetched in order; each Instr appears 1 cycle after its address. Halted=1 after the 16th accept, Retired=16, Address 16 never enabled.
- MEM_LAT=3, Instr_ready=0 for 5 cycles at PC=2 → Enable_i high for exactly 3 cycles per fetch. Instr/Instr_pc=2 held stable through the stall, Retired unchanged until ready.
- Branch_taken with target 9 while in VALID at PC=4, Instr_ready=1 same cycle → word 4 discarded, Retired unchanged. Next Instr_pc=9, then 10.
- Branch_taken with target 0 during the FETCH wait of PC=7 (MEM_LAT=3) → fetch of 7 aborted; address 0 held for a full 3 cycles; Instr_pc=0 delivered.
- Reset low mid-FETCH at PC=5 → all outputs return to reset values asynchronously. After release, state is IDLE until Start; restart begins at address 0 with Retired=0.
- ADDR_W=4, END_ADDR=0, START_ADDR=14 → fetches 14, 15, then the PC wraps to 0 and the unit halts. Retired=2.
